// File: rtl/alu_step_sequencer.sv
// Control sequencer for one 3-register ALU instruction (op Ra, Rb, Rc):
// fetch, decode, execute and writeback select/enable lines for the datapath.
module alu_step_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 32,
  parameter int ZLO_IDX  = 19,
  parameter int PC_IDX   = 20,
  parameter int MDR_IDX  = 21,
  parameter int ALU_W    = 16,
  parameter int MEM_WAIT = 0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             run,
  input  logic [31:0]      ir_word,
  output logic [SEL_W-1:0] Rin,
  output logic [SEL_W-1:0] Rout,
  output logic             IRin,
  output logic             MARin,
  output logic             RYin,
  output logic             MDRread,
  output logic [ALU_W-1:0] ALUControl,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [2:0]       step
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6,
    S_DONE = 3'd7
  } state_t;

  typedef logic [SEL_W-1:0] sel_t;

  localparam logic [4:0] REG_LIMIT = 5'(NUM_REGS);
  localparam logic [4:0] OP_MAX    = 5'd9;

  state_t     state, state_next;
  logic [3:0] wait_cnt, wait_cnt_next;
  logic       illegal_next;
  logic [4:0] op_q;
  logic [3:0] ra_q, rc_q;

  logic [4:0] op_w;
  logic [3:0] ra_w, rb_w, rc_w;
  logic       ir_bad;
  logic       unused_ir_low;

  assign op_w = ir_word[31:27];
  assign ra_w = ir_word[26:23];
  assign rb_w = ir_word[22:19];
  assign rc_w = ir_word[18:15];
  assign unused_ir_low = ^ir_word[14:0];

  // Any register field beyond the implemented file traps like a bad opcode.
  assign ir_bad = (op_w > OP_MAX) || ({1'b0, ra_w} >= REG_LIMIT) ||
                  ({1'b0, rb_w} >= REG_LIMIT) || ({1'b0, rc_w} >= REG_LIMIT);

  function automatic sel_t sel(input int idx);
    return sel_t'(1) << idx;
  endfunction

  always_ff @(posedge clock or posedge clear) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (clear) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      illegal  <= 1'b0;
      op_q     <= 5'd0;
      ra_q     <= 4'd0;
      rc_q     <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      illegal  <= illegal_next;
      if (state == S_T3) begin
        op_q <= op_w;
        ra_q <= ra_w;
        rc_q <= rc_w;
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path
    // leaves it unassigned, which would infer a latch.
    state_next    = state;
    wait_cnt_next = wait_cnt;
    illegal_next  = illegal;
    unique case (state)
      S_IDLE: if (start) begin
        state_next   = S_T0;
        illegal_next = 1'b0;
      end
      S_T0: begin
        state_next    = S_T1;
        wait_cnt_next = 4'(MEM_WAIT);
      end
      S_T1: begin
        if (wait_cnt == 4'd0) state_next = S_T2;
        else                  wait_cnt_next = wait_cnt - 4'd1;
      end
      S_T2: state_next = S_T3;
      S_T3: begin
        if (ir_bad) begin
          state_next   = S_IDLE;
          illegal_next = 1'b1;
        end else begin
          state_next = S_T4;
        end
      end
      S_T4:   state_next = S_T5;
      S_T5:   state_next = S_DONE;
      S_DONE: state_next = run ? S_T0 : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Strobes decode the registered state, so clear drops them at once.
  always_comb begin
    Rin        = '0;
    Rout       = '0;
    IRin       = 1'b0;
    MARin      = 1'b0;
    RYin       = 1'b0;
    MDRread    = 1'b0;
    ALUControl = '0;
    unique case (state)
      S_T0: begin
        Rout  = sel(PC_IDX);
        MARin = 1'b1;
        Rin   = sel(ZLO_IDX);
      end
      S_T1: begin
        Rout    = sel(ZLO_IDX);
        Rin     = sel(PC_IDX) | sel(MDR_IDX);
        MDRread = 1'b1;
      end
      S_T2: begin
        Rout = sel(MDR_IDX);
        IRin = 1'b1;
      end
      S_T3: if (!ir_bad) begin
        Rout = sel(int'(rb_w));
        RYin = 1'b1;
      end
      S_T4: begin
        Rout       = sel(int'(rc_q));
        Rin        = sel(ZLO_IDX);
        ALUControl = ALU_W'(op_q + 5'd1);
      end
      S_T5: begin
        Rout = sel(ZLO_IDX);
        Rin  = sel(int'(ra_q));
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign step = state;

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Directed bench for alu_step_sequencer: default, MEM_WAIT=3 and
// NUM_REGS=8/SEL_W=24 instances side by side on one clock and clear.
module tb_alu_step_sequencer;

  logic clock, clear;
  int   checks, failures;
  bit   mon_en;

  logic        start0, run0;
  logic [31:0] ir0, rin0, rout0;
  logic        irin0, marin0, ryin0, mdrread0, busy0, done0, illegal0;
  logic [15:0] alu0;
  logic [2:0]  step0;

  logic        start3, run3;
  logic [31:0] ir3, rin3, rout3;
  logic        irin3, marin3, ryin3, mdrread3, busy3, done3, illegal3;
  logic [15:0] alu3;
  logic [2:0]  step3;

  logic        start8, run8;
  logic [31:0] ir8;
  logic [23:0] rin8, rout8;
  logic        irin8, marin8, ryin8, mdrread8, busy8, done8, illegal8;
  logic [15:0] alu8;
  logic [2:0]  step8;

  alu_step_sequencer dut0 (
    .clock(clock), .clear(clear), .start(start0), .run(run0), .ir_word(ir0),
    .Rin(rin0), .Rout(rout0), .IRin(irin0), .MARin(marin0), .RYin(ryin0),
    .MDRread(mdrread0), .ALUControl(alu0), .busy(busy0), .done(done0),
    .illegal(illegal0), .step(step0)
  );

  alu_step_sequencer #(.MEM_WAIT(3)) dut3 (
    .clock(clock), .clear(clear), .start(start3), .run(run3), .ir_word(ir3),
    .Rin(rin3), .Rout(rout3), .IRin(irin3), .MARin(marin3), .RYin(ryin3),
    .MDRread(mdrread3), .ALUControl(alu3), .busy(busy3), .done(done3),
    .illegal(illegal3), .step(step3)
  );

  alu_step_sequencer #(.NUM_REGS(8), .SEL_W(24)) dut8 (
    .clock(clock), .clear(clear), .start(start8), .run(run8), .ir_word(ir8),
    .Rin(rin8), .Rout(rout8), .IRin(irin8), .MARin(marin8), .RYin(ryin8),
    .MDRread(mdrread8), .ALUControl(alu8), .busy(busy8), .done(done8),
    .illegal(illegal8), .step(step8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // T1 legitimately loads PC and MDR together; every other state is one-hot or idle.
  function automatic bit rin_ok(input logic [2:0] st, input logic [31:0] rin);
    if (st == 3'd2) return rin == 32'h0030_0000;
    return $onehot0(rin);
  endfunction

  always @(negedge clock) begin
    if (mon_en && !clear) begin
      checks++;
      if (!$onehot0(rout0) || !$onehot0(rout3) || !$onehot0(rout8) ||
          !rin_ok(step0, rin0) || !rin_ok(step3, rin3) || !rin_ok(step8, {8'h0, rin8})) begin
        failures++;
        $display("FAIL onehot t=%0t rout0=%h rin0=%h rout3=%h rin3=%h rout8=%h rin8=%h",
                 $time, rout0, rin0, rout3, rin3, rout8, rin8);
      end
    end
  end

  task automatic test_reset();
    clear = 1'b1;
    start0 = 0; run0 = 0; ir0 = '0;
    start3 = 0; run3 = 0; ir3 = '0;
    start8 = 0; run8 = 0; ir8 = '0;
    repeat (2) cycle();
    checks++; if (rin0 !== 32'h0) begin failures++; $display("FAIL reset_rin got=%h exp=0", rin0); end
    checks++; if (rout0 !== 32'h0) begin failures++; $display("FAIL reset_rout got=%h exp=0", rout0); end
    checks++; if ({irin0, marin0, ryin0, mdrread0} !== 4'b0) begin failures++;
      $display("FAIL reset_strobes got=%b exp=0000", {irin0, marin0, ryin0, mdrread0}); end
    checks++; if (alu0 !== 16'h0) begin failures++; $display("FAIL reset_alu got=%h exp=0", alu0); end
    checks++; if ({busy0, done0, illegal0} !== 3'b0) begin failures++;
      $display("FAIL reset_flags got=%b exp=000", {busy0, done0, illegal0}); end
    checks++; if ({step0, step3, step8} !== 9'b0) begin failures++;
      $display("FAIL reset_step got=%o exp=000", {step0, step3, step8}); end
    clear = 1'b0;
    mon_en = 1'b1;
    cycle();
  endtask

  // ROR R6, R4, R2 on the default instance: full strobe table per cycle.
  task automatic test_ror();
    logic [31:0] exp_rin  [1:7] = '{32'h0008_0000, 32'h0030_0000, 32'h0, 32'h0,
                                    32'h0008_0000, 32'h0000_0040, 32'h0};
    logic [31:0] exp_rout [1:7] = '{32'h0010_0000, 32'h0008_0000, 32'h0020_0000,
                                    32'h0000_0010, 32'h0000_0004, 32'h0008_0000, 32'h0};
    logic [3:0]  exp_strb [1:7] = '{4'b0100, 4'b0001, 4'b1000, 4'b0010, 4'b0, 4'b0, 4'b0};
    logic [15:0] exp_alu  [1:7] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd8, 16'd0, 16'd0};
    ir0 = 32'h3B21_0000;
    start0 = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      cycle();
      start0 = 1'b0;
      if (n <= 7) begin
        checks++;
        if (step0 !== 3'(n) || rin0 !== exp_rin[n] || rout0 !== exp_rout[n] ||
            {irin0, marin0, ryin0, mdrread0} !== exp_strb[n] || alu0 !== exp_alu[n] ||
            busy0 !== 1'b1 || done0 !== (n == 7)) begin
          failures++;
          $display("FAIL ror_cycle%0d step=%0d rin=%h rout=%h strb=%b alu=%0d busy=%b done=%b exp step=%0d rin=%h rout=%h strb=%b alu=%0d busy=1 done=%b",
                   n, step0, rin0, rout0, {irin0, marin0, ryin0, mdrread0}, alu0, busy0, done0,
                   n, exp_rin[n], exp_rout[n], exp_strb[n], exp_alu[n], n == 7);
        end
      end else begin
        checks++;
        if (step0 !== 3'd0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
          failures++;
          $display("FAIL ror_return step=%0d busy=%b done=%b exp 0/0/0", step0, busy0, done0);
        end
      end
    end
  endtask

  // ADD R1, R2, R3 with three memory wait states.
  task automatic test_mem_wait();
    int t1_cycles = 0;
    int done_at = 0;
    ir3 = 32'h0091_8000;
    start3 = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      cycle();
      start3 = 1'b0;
      if (step3 == 3'd2) begin
        t1_cycles++;
        checks++;
        if (rout3 !== 32'h0008_0000 || rin3 !== 32'h0030_0000 || mdrread3 !== 1'b1) begin
          failures++;
          $display("FAIL memwait_t1_strobes rout=%h rin=%h mdrread=%b exp 00080000/00300000/1",
                   rout3, rin3, mdrread3);
        end
      end
      if (step3 == 3'd5) begin
        checks++;
        if (alu3 !== 16'd1) begin failures++; $display("FAIL memwait_alu got=%0d exp=1", alu3); end
      end
      if (done3 && done_at == 0) done_at = n;
    end
    checks++; if (t1_cycles != 4) begin failures++; $display("FAIL memwait_t1_len got=%0d exp=4", t1_cycles); end
    checks++; if (done_at != 10) begin failures++; $display("FAIL memwait_latency got=%0d exp=10", done_at); end
    checks++; if (step3 !== 3'd0) begin failures++; $display("FAIL memwait_idle got=%0d exp=0", step3); end
  endtask

  // Opcode 0x1F traps after T3; a later start clears the sticky flag.
  task automatic test_illegal();
    bit saw_late = 0;
    bit low_rin  = 0;
    ir0 = 32'hF800_0000;
    start0 = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      cycle();
      start0 = 1'b0;
      if (rin0[15:0] != 16'h0) low_rin = 1;
      if (step0 == 3'd5 || step0 == 3'd6 || done0) saw_late = 1;
      if (n == 4) begin
        checks++;
        if (step0 !== 3'd4 || illegal0 !== 1'b0) begin failures++;
          $display("FAIL illegal_t3 step=%0d illegal=%b exp 4/0", step0, illegal0); end
      end
      if (n == 5) begin
        checks++;
        if (step0 !== 3'd0 || illegal0 !== 1'b1 || busy0 !== 1'b0) begin failures++;
          $display("FAIL illegal_trap step=%0d illegal=%b busy=%b exp 0/1/0", step0, illegal0, busy0); end
      end
    end
    checks++; if (saw_late) begin failures++; $display("FAIL illegal_skip got=reached_T4plus exp=skipped"); end
    checks++; if (low_rin) begin failures++; $display("FAIL illegal_rin got=register_write exp=none"); end
    checks++; if (illegal0 !== 1'b1) begin failures++; $display("FAIL illegal_sticky got=%b exp=1", illegal0); end
    ir0 = 32'h3B21_0000;
    start0 = 1'b1;
    cycle();
    start0 = 1'b0;
    checks++;
    if (illegal0 !== 1'b0 || step0 !== 3'd1) begin failures++;
      $display("FAIL illegal_clear_by_start illegal=%b step=%0d exp 0/1", illegal0, step0); end
    repeat (8) cycle();
    checks++; if (step0 !== 3'd0) begin failures++; $display("FAIL illegal_followup_idle got=%0d exp=0", step0); end
  endtask

  // run=1: ADD then SUB with no idle gap; run drops during the SUB.
  task automatic test_back_to_back();
    int busy_drops = 0;
    run0 = 1'b1;
    ir0 = 32'h0091_8000;
    start0 = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      cycle();
      start0 = 1'b0;
      if (n == 8) ir0 = 32'h0AB3_8000;
      if (n == 10) run0 = 1'b0;
      if (n <= 14 && busy0 !== 1'b1) busy_drops++;
      case (n)
        5: begin checks++; if (alu0 !== 16'd1) begin failures++; $display("FAIL b2b_alu_add got=%0d exp=1", alu0); end end
        6: begin checks++; if (rin0 !== 32'h0000_0002) begin failures++; $display("FAIL b2b_rin_add got=%h exp=00000002", rin0); end end
        7: begin checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL b2b_done1 got=%b exp=1", done0); end end
        8: begin checks++; if (step0 !== 3'd1) begin failures++; $display("FAIL b2b_restart got=%0d exp=1", step0); end end
        11: begin checks++; if (rout0 !== 32'h0000_0040) begin failures++; $display("FAIL b2b_rout_rb got=%h exp=00000040", rout0); end end
        12: begin checks++; if (alu0 !== 16'd2) begin failures++; $display("FAIL b2b_alu_sub got=%0d exp=2", alu0); end end
        13: begin checks++; if (rin0 !== 32'h0000_0020) begin failures++; $display("FAIL b2b_rin_sub got=%h exp=00000020", rin0); end end
        14: begin checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL b2b_done2 got=%b exp=1", done0); end end
        15: begin checks++; if (step0 !== 3'd0 || busy0 !== 1'b0) begin failures++;
              $display("FAIL b2b_stop step=%0d busy=%b exp 0/0", step0, busy0); end end
        default: ;
      endcase
    end
    checks++; if (busy_drops != 0) begin failures++; $display("FAIL b2b_busy_gap got=%0d exp=0", busy_drops); end
  endtask

  // clear between edges during T4: outputs drop at once, no T5 write follows.
  task automatic test_clear_mid();
    bit saw_write = 0;
    bit left_idle = 0;
    ir0 = 32'h3B21_0000;
    start0 = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      cycle();
      start0 = 1'b0;
    end
    checks++;
    if (step0 !== 3'd5 || rin0 !== 32'h0008_0000) begin failures++;
      $display("FAIL clear_pre step=%0d rin=%h exp 5/00080000", step0, rin0); end
    #2;
    clear = 1'b1;
    #1;
    checks++;
    if (rin0 !== 32'h0 || rout0 !== 32'h0 || alu0 !== 16'h0 || step0 !== 3'd0 ||
        busy0 !== 1'b0 || done0 !== 1'b0 || {irin0, marin0, ryin0, mdrread0} !== 4'b0) begin
      failures++;
      $display("FAIL clear_async rin=%h rout=%h alu=%h step=%0d busy=%b exp all zero",
               rin0, rout0, alu0, step0, busy0);
    end
    cycle();
    clear = 1'b0;
    for (int n = 0; n < 8; n++) begin
      cycle();
      if (rin0[6]) saw_write = 1;
      if (step0 != 3'd0) left_idle = 1;
    end
    checks++; if (saw_write) begin failures++; $display("FAIL clear_no_t5 got=Rin6_set exp=never"); end
    checks++; if (left_idle) begin failures++; $display("FAIL clear_stay_idle got=left_idle exp=idle"); end
  endtask

  // NUM_REGS=8, SEL_W=24: Ra=9 traps; Ra=7 is the top legal register.
  task automatic test_sweep();
    bit low_rin = 0;
    bit saw_done = 0;
    ir8 = 32'h0489_0000;
    start8 = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      cycle();
      start8 = 1'b0;
      if (rin8[7:0] != 8'h0) low_rin = 1;
      if (done8) saw_done = 1;
      if (n == 5) begin
        checks++;
        if (step8 !== 3'd0 || illegal8 !== 1'b1) begin failures++;
          $display("FAIL sweep_trap step=%0d illegal=%b exp 0/1", step8, illegal8); end
      end
    end
    checks++; if (low_rin || saw_done) begin failures++;
      $display("FAIL sweep_no_write got rin_low=%b done=%b exp 0/0", low_rin, saw_done); end
    ir8 = 32'h0389_0000;
    start8 = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      cycle();
      start8 = 1'b0;
      case (n)
        1: begin checks++; if (illegal8 !== 1'b0) begin failures++; $display("FAIL sweep_clear_illegal got=%b exp=0", illegal8); end end
        4: begin checks++; if (rout8 !== 24'h00_0002) begin failures++; $display("FAIL sweep_rout_rb got=%h exp=000002", rout8); end end
        6: begin checks++; if (rin8 !== 24'h00_0080) begin failures++; $display("FAIL sweep_rin_r7 got=%h exp=000080", rin8); end end
        7: begin checks++; if (done8 !== 1'b1) begin failures++; $display("FAIL sweep_done got=%b exp=1", done8); end end
        default: ;
      endcase
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    mon_en = 1'b0;
    clear = 1'b1;
    test_reset();
    test_ror();
    test_mem_wait();
    test_illegal();
    test_back_to_back();
    test_clear_mid();
    test_sweep();
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
